booth_r4_mult: RTL and testbench

//  Iterative radix-4 Booth multiplier: two product bits per cycle, signed or unsigned

---
 rtl/mult_pkg.sv | 28 ++
 rtl/booth_r4_enc.sv | 22 ++
 rtl/booth_r4_mult.sv | 153 +++++++++++++++
 tb/tb_booth_r4_mult.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// +----------------------------------------------------------------------------+
// | mult_pkg : shared types and helpers for the Booth multiplier family         |
// | Rev 1.0  : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic neg;
        logic two;
        logic zero;
    } booth_digit_t;

    // Even internal width with at least one guard bit above the operand.
    function automatic int ext_width(input int width);
        return (width % 2 == 0) ? width + 2 : width + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_r4_enc.sv
// +----------------------------------------------------------------------------+
// | booth_r4_enc : radix-4 Booth recoder, triplet {b1,b0,b_prev} -> digit       |
// | Rev 1.0      : initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module booth_r4_enc
    import mult_pkg::*;
(
    input  logic [2:0]   trip_i,
    output booth_digit_t digit_o
);

    always_comb begin
        digit_o.zero = (trip_i == 3'b000) || (trip_i == 3'b111);
        digit_o.two  = (trip_i == 3'b011) || (trip_i == 3'b100);
        digit_o.neg  = trip_i[2] & ~(trip_i[1] & trip_i[0]);
    end

endmodule

`default_nettype wire

// File: rtl/booth_r4_mult.sv
// +----------------------------------------------------------------------------+
// | booth_r4_mult : iterative radix-4 Booth multiplier, valid/ready handshakes  |
// | Option BOOTH_MULT_ACC_EN adds in_acc, result = a*b + in_acc.                |
// | Rev 1.0       : initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module booth_r4_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
`ifdef BOOTH_MULT_ACC_EN
    input  logic [2*WIDTH-1:0]   in_acc,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod
);

    localparam int EW = ext_width(WIDTH);
    localparam int N  = EW / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PH = 2 * WIDTH - EW + 1;

    state_t              state_q;
    logic [EW+1:0]       acc_q;
    logic [EW-1:0]       a_q;
    logic [EW-1:0]       b_q;
    logic                bprev_q;
    logic [CW-1:0]       cnt_q;
    logic [2*WIDTH-1:0]  prod_q;
    logic                in_ready_q;
    logic                out_valid_q;
`ifdef BOOTH_MULT_ACC_EN
    logic [2*WIDTH-1:0]  addin_q;
`endif

    logic [EW-1:0]       a_ext_d;
    logic [EW-1:0]       b_ext_d;
    booth_digit_t        digit;
    logic [EW+1:0]       a_sx;
    logic [EW+1:0]       a_x2;
    logic [EW+1:0]       mag;
    logic [EW+1:0]       addend;
    logic [EW+1:0]       sum;
    logic [EW+1:0]       acc_d;
    logic [EW-1:0]       b_d;
    logic [2*WIDTH-1:0]  prod_d;

    booth_r4_enc u_enc (
        .trip_i  ({b_q[1:0], bprev_q}),
        .digit_o (digit)
    );

    always_comb begin
        a_ext_d = {{(EW-WIDTH){in_signed & in_a[WIDTH-1]}}, in_a};
        b_ext_d = {{(EW-WIDTH){in_signed & in_b[WIDTH-1]}}, in_b};
        a_sx    = {{2{a_q[EW-1]}}, a_q};
        a_x2    = {a_q[EW-1], a_q, 1'b0};
        mag     = digit.two ? a_x2 : a_sx;
        addend  = '0;
        if (!digit.zero) begin
            addend = digit.neg ? -mag : mag;
        end
        sum     = acc_q + addend;
        // {acc,B} >>> 2 after the add; the product is the low 2*WIDTH bits of that pair.
        acc_d   = {{2{sum[EW+1]}}, sum[EW+1:2]};
        b_d     = {sum[1:0], b_q[EW-1:2]};
        prod_d  = {sum[PH:0], b_q[EW-1:2]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            bprev_q     <= 1'b0;
            cnt_q       <= '0;
            prod_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef BOOTH_MULT_ACC_EN
            addin_q     <= '0;
`endif
        end else if (flush) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a_ext_d;
                        b_q        <= b_ext_d;
                        bprev_q    <= 1'b0;
                        acc_q      <= '0;
                        cnt_q      <= CW'(N - 1);
`ifdef BOOTH_MULT_ACC_EN
                        addin_q    <= in_acc;
`endif
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    b_q     <= b_d;
                    bprev_q <= b_q[1];
                    if (cnt_q == '0) begin
`ifdef BOOTH_MULT_ACC_EN
                        prod_q <= prod_d + addin_q;
`else
                        prod_q <= prod_d;
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_prod  = prod_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_r4_mult.sv
// +----------------------------------------------------------------------------+
// | tb_booth_r4_mult : self-checking bench for booth_r4_mult (WIDTH=16)         |
// | Rev 1.0          : initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_booth_r4_mult;

    localparam int W = 16;
    localparam int N = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_signed = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [2*W-1:0] in_acc = '0;
    logic          in_ready;
    logic          out_valid;
    logic [2*W-1:0] out_prod;

    always #5 clk = ~clk;

    booth_r4_mult #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef BOOTH_MULT_ACC_EN
        .in_acc    (in_acc),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b,
                                             input logic s, input logic [31:0] acc);
        longint x;
        longint y;
        logic [63:0] p;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        p = 64'(x * y);
        return p[31:0] + acc;
    endfunction

    // Transaction-level model: busy for N edges after accept, then holds result until taken.
    logic        m_busy  = 1'b0;
    logic        m_valid = 1'b0;
    int          m_left  = 0;
    logic [31:0] m_pend  = '0;
    logic [31:0] m_prod  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end else if (flush) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end else if (m_valid) begin
            if (out_ready) m_valid <= 1'b0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
                m_prod  <= m_pend;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (in_valid) begin
            m_busy <= 1'b1;
            m_left <= N;
            m_pend <= ref_prod(in_a, in_b, in_signed, in_acc);
        end
    end

    always @(negedge clk) begin
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("in_ready", 64'(in_ready), 64'(!m_busy && !m_valid));
        if (m_valid) check("out_prod", 64'(out_prod), 64'(m_prod));
    end

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) return;
        end
        check("idle_timeout", 64'(in_ready), 64'(1));
    endtask

    task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [31:0] acc, input logic [31:0] exp);
        int  lat;
        bit  seen;
        wait_idle();
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_acc    = acc;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_a      = 16'($urandom);
        in_b      = 16'($urandom);
        in_signed = ~s;
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'(N));
        check(name, 64'(out_prod), 64'(exp));
        @(posedge clk);
        #1;
        check({name, "_valid_one_cycle"}, 64'(out_valid), 64'(0));
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7FFF;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_out_prod", 64'(out_prod), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        rst = 1'b0;

        do_op("s_m3x7",       16'hFFFD, 16'd7,   1'b1, 32'd0, 32'hFFFFFFEB);
        do_op("u_ffffxffff",  16'hFFFF, 16'hFFFF, 1'b0, 32'd0, 32'hFFFE0001);
        do_op("s_ffffxffff",  16'hFFFF, 16'hFFFF, 1'b1, 32'd0, 32'h00000001);
        do_op("s_8000x8000",  16'h8000, 16'h8000, 1'b1, 32'd0, 32'h40000000);
        do_op("u_8000x8000",  16'h8000, 16'h8000, 1'b0, 32'd0, 32'h40000000);
        do_op("s_7fffx8000",  16'h7FFF, 16'h8000, 1'b1, 32'd0, 32'hC0008000);
`ifdef BOOTH_MULT_ACC_EN
        do_op("acc_m3x7p100", 16'hFFFD, 16'd7,   1'b1, 32'd100, 32'h0000004F);
`endif

        // Backpressure: result held while the consumer stalls.
        wait_idle();
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h5678; in_signed = 1'b0; in_acc = '0;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 40 && !out_valid; k++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_prod", 64'(out_prod), 64'h06260060);
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_in_ready", 64'(in_ready), 64'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_after_accept", 64'(in_ready), 64'(1));

        // Flush during RUN, then flush colliding with a handshake.
        wait_idle();
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h5678;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            check("flush_no_valid", 64'(out_valid), 64'(0));
            @(negedge clk);
        end
        do_op("u_5x6", 16'd5, 16'd6, 1'b0, 32'd0, 32'h0000001E);

        // Reset pulse mid-RUN.
        wait_idle();
        in_valid = 1'b1; in_a = 16'hABCD; in_b = 16'h1357; in_signed = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_out_prod", 64'(out_prod), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        #2 rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("rst_no_stale_valid", 64'(out_valid), 64'(0));
        end

        // Random traffic against the model.
        for (int k = 0; k < 30000; k++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = pick();
            in_b      = pick();
            in_signed = 1'($urandom_range(0, 1));
`ifdef BOOTH_MULT_ACC_EN
            in_acc    = 32'($urandom);
`endif
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
